// File: rtl/mppt_pkg.sv
// rtl/mppt_pkg.sv - shared state encoding and duty defaults for the P&O MPPT controller
package mppt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_REQ    = 3'd2,
        ST_CALC   = 3'd3,
        ST_DECIDE = 3'd4
    } state_e;

    localparam int DUTY_MIN_DEF  = 8;
    localparam int DUTY_MAX_DEF  = 247;
    localparam int DUTY_INIT_DEF = 128;

endpackage

// File: rtl/mppt_settle_timer.sv
// rtl/mppt_settle_timer.sv - down-counter that holds off sampling after each duty change
module settle_timer #(
    parameter int CNT_W = 11
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             run_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // load has priority; otherwise count down while running and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (run_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // counter register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mppt_po_ctrl.sv
// rtl/mppt_po_ctrl.sv - perturb-and-observe maximum power point tracker driving a pwm duty
module mppt_po_ctrl
    import mppt_pkg::*;
#(
    parameter int RESOLUTION    = 8,
    parameter int ADC_W         = 12,
    parameter int STEP          = 1,
    parameter int SETTLE_CYCLES = 1024,
    parameter int DUTY_MIN      = DUTY_MIN_DEF,
    parameter int DUTY_MAX      = DUTY_MAX_DEF,
    parameter int DUTY_INIT     = DUTY_INIT_DEF
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    output logic                  sample_req_o,
    input  logic                  sample_ack_i,
    input  logic [ADC_W-1:0]      v_i,
    input  logic [ADC_W-1:0]      i_i,
    output logic [RESOLUTION-1:0] duty_o,
    output logic                  duty_upd_o,
    output logic                  dir_o,
    output logic [2*ADC_W-1:0]    power_o
);

    localparam int P_W   = 2 * ADC_W;
    localparam int W     = RESOLUTION + 1;
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [W-1:0]          STEP_W = W'(STEP);
    localparam logic [W-1:0]          MIN_W  = W'(DUTY_MIN);
    localparam logic [W-1:0]          MAX_W  = W'(DUTY_MAX);
    localparam logic [CNT_W-1:0]      RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [RESOLUTION-1:0] INIT_D = RESOLUTION'(DUTY_INIT);

    state_e                  state_q, state_d;
    logic                    first_q, first_d;
    logic                    dir_q, dir_d;
    logic [RESOLUTION-1:0]   duty_q, duty_d;
    logic [P_W-1:0]          power_q, power_d;
    logic [P_W-1:0]          p_prev_q, p_prev_d;
    logic [ADC_W-1:0]        v_q, v_d;
    logic [ADC_W-1:0]        i_q, i_d;
    logic                    req_q, req_d;
    logic                    upd_q, upd_d;

    logic                    settle_done;
    logic                    settle_load;
    logic                    settle_run;

    // direction and stepped duty resolved for the DECIDE state
    logic                    dir_res;
    logic [W-1:0]            duty_w;
    logic [W-1:0]            duty_step;
    logic                    hit_clamp;

    // reload on entry to SETTLE from IDLE or DECIDE; count only while settling
    assign settle_load = enable_i && ((state_q == ST_IDLE) || (state_q == ST_DECIDE));
    assign settle_run  = enable_i && (state_q == ST_SETTLE);

    settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (settle_load),
        .load_val_i (RELOAD),
        .run_i      (settle_run),
        .done_o     (settle_done)
    );

    // state register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic; a low enable pulls every state back to IDLE
    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_SETTLE;
                ST_SETTLE: if (settle_done) state_d = ST_REQ;
                ST_REQ:    if (sample_ack_i) state_d = ST_CALC;
                ST_CALC:   state_d = ST_DECIDE;
                ST_DECIDE: state_d = ST_SETTLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // perturbation decision: hold direction on the first pass, reverse when power fell
    always_comb begin
        dir_res   = dir_q;
        duty_w    = {1'b0, duty_q};
        duty_step = duty_w;
        hit_clamp = 1'b0;
        if (!first_q && (power_q < p_prev_q)) begin
            dir_res = ~dir_q;
        end
        if (dir_res) begin
            if (duty_w + STEP_W >= MAX_W) begin
                duty_step = MAX_W;
                hit_clamp = 1'b1;
            end else begin
                duty_step = duty_w + STEP_W;
            end
        end else begin
            if (duty_w <= MIN_W + STEP_W) begin
                duty_step = MIN_W;
                hit_clamp = 1'b1;
            end else begin
                duty_step = duty_w - STEP_W;
            end
        end
    end

    // output and datapath next values; outputs are registered so reset release cannot glitch them
    always_comb begin
        first_d  = first_q;
        dir_d    = dir_q;
        duty_d   = duty_q;
        power_d  = power_q;
        p_prev_d = p_prev_q;
        v_d      = v_q;
        i_d      = i_q;
        upd_d    = 1'b0;
        req_d    = (state_d == ST_REQ);
        if (enable_i) begin
            case (state_q)
                ST_IDLE: begin
                    first_d = 1'b1;
                end
                ST_REQ: begin
                    if (sample_ack_i) begin
                        v_d = v_i;
                        i_d = i_i;
                    end
                end
                ST_CALC: begin
                    power_d = P_W'(v_q) * P_W'(i_q);
                end
                ST_DECIDE: begin
                    first_d  = 1'b0;
                    p_prev_d = power_q;
                    duty_d   = duty_step[RESOLUTION-1:0];
                    dir_d    = hit_clamp ? ~dir_res : dir_res;
                    upd_d    = (duty_step[RESOLUTION-1:0] != duty_q);
                end
                default: ;
            endcase
        end
    end

    // datapath and output registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            first_q  <= 1'b1;
            dir_q    <= 1'b1;
            duty_q   <= INIT_D;
            power_q  <= '0;
            p_prev_q <= '0;
            v_q      <= '0;
            i_q      <= '0;
            req_q    <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            first_q  <= first_d;
            dir_q    <= dir_d;
            duty_q   <= duty_d;
            power_q  <= power_d;
            p_prev_q <= p_prev_d;
            v_q      <= v_d;
            i_q      <= i_d;
            req_q    <= req_d;
            upd_q    <= upd_d;
        end
    end

    assign sample_req_o = req_q;
    assign duty_o       = duty_q;
    assign duty_upd_o   = upd_q;
    assign dir_o        = dir_q;
    assign power_o      = power_q;

endmodule

// File: tb/tb_mppt_po_ctrl.sv
// tb/tb_mppt_po_ctrl.sv - directed self-checking bench for mppt_po_ctrl
module tb_mppt_po_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, en2;
    logic        ack;
    logic [11:0] v, i;
    logic        sel;

    logic        req1, upd1, dir1;
    logic [7:0]  duty1;
    logic [23:0] pwr1;
    logic        req2, upd2, dir2;
    logic [7:0]  duty2;
    logic [23:0] pwr2;

    int n_checks = 0;
    int n_errors = 0;
    int n;
    int cnt;

    always #5 clk = ~clk;

    mppt_po_ctrl #(
        .SETTLE_CYCLES (4)
    ) u_dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .enable_i     (en),
        .sample_req_o (req1),
        .sample_ack_i (ack),
        .v_i          (v),
        .i_i          (i),
        .duty_o       (duty1),
        .duty_upd_o   (upd1),
        .dir_o        (dir1),
        .power_o      (pwr1)
    );

    mppt_po_ctrl #(
        .SETTLE_CYCLES (4),
        .DUTY_INIT     (246)
    ) u_dut_clamp (
        .clk_i        (clk),
        .reset_i      (rst),
        .enable_i     (en2),
        .sample_req_o (req2),
        .sample_ack_i (ack),
        .v_i          (v),
        .i_i          (i),
        .duty_o       (duty2),
        .duty_upd_o   (upd2),
        .dir_o        (dir2),
        .power_o      (pwr2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // count clock edges until the selected DUT raises sample_req_o (bounded)
    task automatic wait_req(output int edges);
        edges = 0;
        while (!(sel ? req2 : req1) && edges < 60) begin
            tick();
            edges++;
        end
    endtask

    // one-edge ack with a sample, then the CALC and DECIDE edges
    task automatic give_sample(input logic [11:0] vv, input logic [11:0] ii);
        ack = 1'b1;
        v   = vv;
        i   = ii;
        tick();
        ack = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; en2 = 1'b0; ack = 1'b0; v = '0; i = '0; sel = 1'b0;
        #12;
        check("rst_duty", duty1, 128);
        check("rst_dir", dir1, 1);
        check("rst_power", pwr1, 0);
        check("rst_req", req1, 0);
        check("rst_upd", upd1, 0);

        // first sample after enable
        @(posedge clk); #1;
        rst = 1'b0;
        en  = 1'b1;
        wait_req(n);
        check("req_latency_enable", n, 5);

        // ack withheld: request must stay up
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (req1) cnt++;
        end
        check("req_held_10", cnt, 10);

        ack = 1'b1; v = 100; i = 10;
        tick();
        ack = 1'b0;
        check("req_drop_after_ack", req1, 0);
        tick();
        check("calc_power", pwr1, 1000);
        check("calc_duty_hold", duty1, 128);
        tick();
        check("first_duty", duty1, 129);
        check("first_upd", upd1, 1);
        check("first_dir", dir1, 1);
        tick();
        check("upd_one_clock", upd1, 0);

        // ack pulse during SETTLE must be ignored; next request on schedule
        ack = 1'b1; v = 999; i = 999;
        tick();
        ack = 1'b0;
        wait_req(n);
        check("settle_ack_ignored", n, 2);

        // hill climb 1200 then 1100
        give_sample(120, 10);
        check("climb2_power", pwr1, 1200);
        check("climb2_duty", duty1, 130);
        check("climb2_dir", dir1, 1);
        wait_req(n);
        check("settle_latency", n, 4);
        give_sample(110, 10);
        check("climb3_duty", duty1, 129);
        check("climb3_dir", dir1, 0);
        check("climb3_upd", upd1, 1);

        // enable drop during CALC
        wait_req(n);
        ack = 1'b1; v = 50; i = 10;
        tick();
        ack = 1'b0;
        en  = 1'b0;
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        check("drop_duty", duty1, 129);
        check("drop_req", req1, 0);
        check("drop_upd", upd1, 0);
        check("drop_power", pwr1, 1100);
        check("drop_dir", dir1, 0);

        // re-enable: first compare skipped (500 < 1100 would otherwise reverse)
        en = 1'b1;
        wait_req(n);
        check("reenable_latency", n, 5);
        give_sample(50, 10);
        check("reenable_power", pwr1, 500);
        check("reenable_duty", duty1, 128);
        check("reenable_dir", dir1, 0);
        wait_req(n);
        give_sample(60, 10);
        check("equal_or_rise_duty", duty1, 127);

        // async reset between edges in SETTLE
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("async_duty", duty1, 128);
        check("async_dir", dir1, 1);
        check("async_power", pwr1, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_req(n);
        check("post_reset_latency", n, 5);
        give_sample(100, 10);
        check("post_reset_duty", duty1, 129);

        // upper clamp on the second instance
        en = 1'b0;
        tick();
        sel = 1'b1;
        en2 = 1'b1;
        wait_req(n);
        check("clamp_latency", n, 5);
        give_sample(100, 10);
        check("clamp_duty_max", duty2, 247);
        check("clamp_dir", dir2, 0);
        check("clamp_upd", upd2, 1);
        wait_req(n);
        give_sample(110, 10);
        check("clamp_back", duty2, 246);
        check("clamp_back_dir", dir2, 0);
        wait_req(n);
        give_sample(120, 10);
        check("clamp_back2", duty2, 245);
        check("main_idle_duty", duty1, 129);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
